// File: rtl/fifo_framer_pkg.sv
// Shared definitions for the FIFO burst framer: state encodings and
// default widths/limits used as parameter defaults.
package fifo_framer_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BURST_LEN  = 16;
  localparam int DEF_BCNT_WIDTH = 5;
  localparam int DEF_TIMEOUT    = 8;
  localparam int DEF_TCNT_WIDTH = 4;

  // State is a direct image of the hold stage: empty, full-not-last, full-last.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPEN  = 2'd1,
    ST_CLOSE = 2'd2
  } state_e;

endpackage

// File: rtl/framer_idle_cnt.sv
// Saturating idle counter for the burst framer. Counts consecutive idle
// cycles; done is asserted combinationally on the increment that reaches
// the limit so the caller can close the burst on that same edge.
module framer_idle_cnt
  import fifo_framer_pkg::*;
#(
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int TCNT_WIDTH = DEF_TCNT_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic done
);

  localparam logic [TCNT_WIDTH-1:0] LIMIT = TCNT_WIDTH'(TIMEOUT);

  logic [TCNT_WIDTH-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise increment until saturated at LIMIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = inc && (cnt_q >= (LIMIT - 1'b1));

endmodule

// File: rtl/fifo_burst_framer.sv
// FIFO burst framer: drains a show-ahead FIFO read port into a valid/ready
// stream, grouping beats into bursts of up to BURST_LEN and flagging the
// final beat with m_last. One word is held back so m_last is known before
// the beat is presented.
// Optional macro FRAMER_TIMEOUT_EN: when defined, an open burst is also
// closed after the FIFO has been empty for TIMEOUT consecutive cycles.
module fifo_burst_framer
  import fifo_framer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int BCNT_WIDTH = DEF_BCNT_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int TCNT_WIDTH = DEF_TCNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_pop,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam logic [BCNT_WIDTH-1:0] BURST_LIM = BCNT_WIDTH'(BURST_LEN);
  // A single-beat burst is complete as soon as its first word is held.
  localparam state_e FIRST_ST = (BURST_LEN == 1) ? ST_CLOSE : ST_OPEN;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [BCNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_last_q, m_last_d;

  logic hold_vld;
  logic adv;
  logic pop;
  logic timeout_hit;

  assign hold_vld = (state_q != ST_IDLE);
  assign adv      = !m_valid_q || m_ready;
  // Popping while the hold is full is only safe if the held word can move
  // into the output stage on the same edge.
  assign pop      = rst_n && !clear && !fifo_empty && (!hold_vld || adv);
  assign fifo_pop = pop;

`ifdef FRAMER_TIMEOUT_EN
  logic idle_inc;
  logic idle_clr;

  // Only an open burst with nothing to pop counts as idle; empty FIFO
  // means no pop can happen, so any pop clears the count implicitly.
  assign idle_inc = (state_q == ST_OPEN) && fifo_empty;
  assign idle_clr = clear || !idle_inc || timeout_hit;

  framer_idle_cnt #(
    .TIMEOUT    (TIMEOUT),
    .TCNT_WIDTH (TCNT_WIDTH)
  ) u_idle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (idle_clr),
    .inc   (idle_inc),
    .done  (timeout_hit)
  );
`else
  // Timeout parameters have no effect in this build.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{TCNT_WIDTH'(TIMEOUT)};
  assign timeout_hit        = 1'b0;
`endif

  // Next-state and datapath decode for the hold/output stages.
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    beat_cnt_d  = beat_cnt_q;
    // An accepted beat leaves the output empty unless reloaded below.
    m_valid_d   = !adv;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pop) begin
          hold_data_d = fifo_data;
          beat_cnt_d  = BCNT_WIDTH'(1);
          state_d     = FIRST_ST;
        end
      end

      ST_OPEN: begin
        if (pop) begin
          m_valid_d   = 1'b1;
          m_data_d    = hold_data_q;
          m_last_d    = 1'b0;
          hold_data_d = fifo_data;
          beat_cnt_d  = beat_cnt_q + 1'b1;
          state_d     = ((beat_cnt_q + 1'b1) == BURST_LIM) ? ST_CLOSE : ST_OPEN;
        end else if (timeout_hit) begin
          state_d = ST_CLOSE;
        end
      end

      ST_CLOSE: begin
        if (adv) begin
          m_valid_d  = 1'b1;
          m_data_d   = hold_data_q;
          m_last_d   = 1'b1;
          beat_cnt_d = '0;
          if (pop) begin
            hold_data_d = fifo_data;
            beat_cnt_d  = BCNT_WIDTH'(1);
            state_d     = FIRST_ST;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, hold and output registers; reset and clear flush everything.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state_q     <= ST_IDLE;
      hold_data_q <= '0;
      beat_cnt_q  <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      beat_cnt_q  <= beat_cnt_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;

endmodule

// File: doc/fifo_burst_framer.md
Name: fifo_burst_framer

Overview:
- Sits directly downstream of the synchronous FIFO.
- Drains the FIFO's show-ahead read port (empty, data_out, pop) into a valid/ready stream.
- Groups beats into bursts and marks the final beat with m_last. A burst closes after BURST_LEN beats, or when the FIFO has stayed empty for TIMEOUT cycles while a burst is open.
- Holds back one word so m_last is decided before the beat is presented.

Parameters:
- DATA_WIDTH, 8: width of FIFO data and stream data.
- BURST_LEN, 16: maximum beats per burst. Legal range 1..2**BCNT_WIDTH-1.
- BCNT_WIDTH, 5: width of the beat counter.
- TIMEOUT, 8: consecutive idle cycles before an open burst is closed. Legal range 1..2**TCNT_WIDTH-1.
- TCNT_WIDTH, 4: width of the idle counter.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: system reset, active-low.
- clear, input, 1: synchronous flush. Abandons held and output words and returns to IDLE.
- fifo_empty, input, 1: FIFO empty flag.
- fifo_data, input, DATA_WIDTH: FIFO head word. Combinational and valid whenever fifo_empty=0.
- fifo_pop, output, 1: pop request to the FIFO. Combinational.
- m_valid, output, 1: stream beat valid.
- m_ready, input, 1: downstream accepts the beat.
- m_data, output, DATA_WIDTH: stream beat data.
- m_last, output, 1: final beat of the burst.

Behaviour:
- Interface (already decided): one clock, clk. Reset is synchronous and active-low on rst_n, sampled only at posedge clk. While rst_n=0, fifo_pop=0.
- Reset and clear values: state=IDLE, m_valid=0, m_data=0, m_last=0, hold_vld=0, hold_last=0, beat_cnt=0, idle_cnt=0. clear has the same effect as reset but needs rst_n=1. fifo_pop=0 while clear=1.
- Registers:
  - Output stage: m_valid, m_data, m_last.
  - Hold stage: hold_vld, hold_data, hold_last.
  - Counters: beat_cnt, idle_cnt.
- Definitions:
  - adv = !m_valid || m_ready (the output stage can load this cycle).
  - fifo_pop = !fifo_empty && (!hold_vld || adv).
- Pop action: fifo_data is captured into hold at the same posedge.
- States (derived from the hold stage):
  - IDLE: hold empty.
  - OPEN: hold full, hold_last=0.
  - CLOSE: hold full, hold_last=1.
- IDLE:
  - On pop: hold←word, beat_cnt←1, hold_last←(BURST_LEN==1). Next state is OPEN, or CLOSE when BURST_LEN=1.
- OPEN:
  - On pop (implies adv): out←{hold_data, last=0}, hold←new word, beat_cnt+1. hold_last←(beat_cnt+1==BURST_LEN).
  - No pop: idle_cnt increments. Reaching TIMEOUT sets hold_last (go to CLOSE) and clears idle_cnt.
  - Any pop clears idle_cnt.
- CLOSE:
  - When adv: out←{hold_data, last=1} and beat_cnt←0.
  - If a pop occurs in the same cycle, the new word enters hold as beat 1 of the next burst.
  - Otherwise next state is IDLE.
  - No pop while the output is blocked.
- Output handshake:
  - m_valid drops after acceptance if nothing is loaded.
  - m_data and m_last are stable while m_valid && !m_ready.
- Latency:
  - Non-final beat: appears on m_valid one cycle after the following word is popped.
  - BURST_LEN-th beat: appears one cycle after entering CLOSE, given adv.
- Throughput: one beat per cycle when the FIFO is non-empty and m_ready=1.
- Backpressure: while m_ready=0 with m_valid=1 and hold full, fifo_pop=0. No data loss or duplication.
- Counter wrap: beat_cnt never exceeds BURST_LEN. idle_cnt saturates at TIMEOUT.

Optional Feature:
- Macro: FRAMER_TIMEOUT_EN.
- Defined: idle timeout closes open bursts as described above.
- Undefined: idle_cnt logic is removed, and bursts close only on BURST_LEN. A held word waits indefinitely for the next FIFO word.

Decomposition:
- Shared package file fifo_framer_pkg:
  - State encodings ST_IDLE=2'd0, ST_OPEN=2'd1, ST_CLOSE=2'd2.
  - Default widths and limits.
- Sub-module framer_idle_cnt: saturating idle counter with clear, increment, and done output. Instantiated only under FRAMER_TIMEOUT_EN.

Test Plan:
- Reset with rst_n=0 for 3 cycles while FIFO holds data → fifo_pop=0 and m_valid=0 throughout; first pop comes after rst_n=1.
- Push 16 words 0x00..0x0F, m_ready=1 → 16 consecutive beats; m_last=1 only on 0x0F; exactly 16 pops.
- Push 3 words 0xA0..0xA2 then stop, FRAMER_TIMEOUT_EN defined, TIMEOUT=8 → 0xA0 and 0xA1 emit with last=0; 0xA2 emits with last=1 exactly 8 idle cycles after its pop plus 1.
- Same stimulus without FRAMER_TIMEOUT_EN → 0xA2 withheld for 100 cycles; after pushing 0xA3, 0xA2 emits with last=0.
- Stream 40 words with m_ready toggling randomly (50%) → output is in-order 0..39; m_last on beats 15, 31; data stable while stalled; no pop while output and hold are full.
- Assert clear mid-burst with m_valid=1, m_ready=0 → next cycle m_valid=0 and state IDLE; the following burst restarts its beat count at 1.
